// File: rtl/receptor_serial_byte_if.sv
// Line-side and holding-register-side signals of the serial byte receiver.
// The receiver takes the slave modport. Whatever drives rx and consumes the byte takes the master modport.
interface receptor_serial_byte_if;
  logic       rx;
  logic [7:0] data_out;
  logic       load;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data_out,
    input  load,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data_out,
    output load,
    output frame_err,
    output busy
  );
endinterface : receptor_serial_byte_if

// File: rtl/receptor_serial_byte.sv
// 8N1 UART-style receiver with an LSB-first frame and mid-bit sampling.
// It pulses load for one cycle per good frame, which updates the downstream 8-bit holding register.
module receptor_serial_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  receptor_serial_byte_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data_out;
  logic             r_load;
  logic             r_frame_err;
  logic             r_busy;

  // rx is asynchronous to clk. Both flops reset to the idle level, so the line does not look like a start bit while reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // NOTE: all state in this block uses non-blocking assignments. Every branch therefore reads the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      // NOTE: the shift register does not need a reset, because it is fully rewritten before use. It is cleared anyway so that no partial byte survives a reset.
      r_shift     <= '0;
      r_data_out  <= '0;
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_load      <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // IDLE is entered together with load, so a start bit that follows the stop bit directly is still caught.
        STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_data_out <= r_shift;
              r_load     <= 1'b1;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (r_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.load      = r_load;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;

  a_load_ferr_excl: assert property (@(posedge clk) !(r_load && r_frame_err));

endmodule : receptor_serial_byte

// File: tb/tb_receptor_serial_byte.sv
// Directed bench for receptor_serial_byte with CLKS_PER_BIT=16.
// A monitor records every load and frame_err pulse, and the main sequence checks against hand-computed values.
module tb_receptor_serial_byte;

  localparam int CPB = 16;
  localparam int LOAD_LAT = 2 + 8 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  receptor_serial_byte_if u_if ();

  receptor_serial_byte #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int load_cnt = 0;
  int ferr_cnt = 0;
  int overlap_cnt = 0;
  int load_cyc_q[$];
  logic [7:0] load_data_q[$];

  always @(posedge clk) begin
    #2;
    cyc++;
    if (u_if.load === 1'b1) begin
      load_cnt++;
      load_cyc_q.push_back(cyc);
      load_data_q.push_back(u_if.data_out);
    end
    if (u_if.frame_err === 1'b1) ferr_cnt++;
    if (u_if.load === 1'b1 && u_if.frame_err === 1'b1) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #4;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    u_if.rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      step(CPB);
    end
    u_if.rx = stop_bit;
    step(CPB);
  endtask

  int fall_cyc;
  int n_load0;
  int n_ferr0;
  int idx;
  int waited;
  logic dropped;

  initial begin
    reset   = 1'b1;
    u_if.rx = 1'b1;
    step(3);
    check("reset_data_out", u_if.data_out, 8'h00);
    check("reset_load", u_if.load, 1'b0);
    check("reset_frame_err", u_if.frame_err, 1'b0);
    check("reset_busy", u_if.busy, 1'b0);
    reset = 1'b0;
    step(50);

    // Frame 0xA5 with a good stop bit
    n_load0  = load_cnt;
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    step(5);
    check("a5_load_count", load_cnt - n_load0, 1);
    check("a5_latency", (load_cyc_q.size() > n_load0) ? load_cyc_q[n_load0] - fall_cyc : -1, LOAD_LAT);
    check("a5_data_out", u_if.data_out, 8'hA5);
    check("a5_no_ferr", ferr_cnt, 0);

    // Start-bit glitch of 4 cycles
    n_load0 = load_cnt;
    u_if.rx = 1'b0;
    step(4);
    check("glitch_busy_high", u_if.busy, 1'b1);
    u_if.rx = 1'b1;
    dropped = 1'b0;
    waited  = 0;
    while (!dropped && waited < 16) begin
      step(1);
      waited++;
      if (u_if.busy === 1'b0) dropped = 1'b1;
    end
    check("glitch_busy_drop", dropped, 1'b1);
    step(CPB);
    check("glitch_no_load", load_cnt - n_load0, 0);
    check("glitch_no_ferr", ferr_cnt, 0);
    check("glitch_data_kept", u_if.data_out, 8'hA5);

    // Frame 0x3C with the stop bit low, then a 40-cycle break
    n_load0 = load_cnt;
    n_ferr0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    step(40);
    check("break_busy_held", u_if.busy, 1'b1);
    check("break_ferr_count", ferr_cnt - n_ferr0, 1);
    check("break_no_load", load_cnt - n_load0, 0);
    check("break_data_kept", u_if.data_out, 8'hA5);
    u_if.rx = 1'b1;
    step(6);
    check("break_busy_released", u_if.busy, 1'b0);
    check("break_ferr_once", ferr_cnt - n_ferr0, 1);

    // Back-to-back frames 0x00 and 0xFF with no idle gap between them
    step(10);
    n_load0  = load_cnt;
    fall_cyc = cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(5);
    check("b2b_load_count", load_cnt - n_load0, 2);
    idx = n_load0;
    check("b2b_first_latency", (load_cyc_q.size() > idx) ? load_cyc_q[idx] - fall_cyc : -1, LOAD_LAT);
    check("b2b_spacing", (load_cyc_q.size() > idx + 1) ? load_cyc_q[idx+1] - load_cyc_q[idx] : -1, 10 * CPB);
    check("b2b_first_data", (load_data_q.size() > idx) ? load_data_q[idx] : 8'hxx, 8'h00);
    check("b2b_second_data", (load_data_q.size() > idx + 1) ? load_data_q[idx+1] : 8'hxx, 8'hFF);
    check("b2b_data_out", u_if.data_out, 8'hFF);

    // Reset pulse in the middle of data bit 4 of frame 0xF5
    step(10);
    n_load0 = load_cnt;
    n_ferr0 = ferr_cnt;
    u_if.rx = 1'b0;
    step(CPB);
    u_if.rx = 1'b1; step(CPB);
    u_if.rx = 1'b0; step(CPB);
    u_if.rx = 1'b1; step(CPB);
    u_if.rx = 1'b0; step(CPB);
    u_if.rx = 1'b1;
    step(CPB / 2);
    reset = 1'b1;
    step(1);
    check("midrst_busy", u_if.busy, 1'b0);
    check("midrst_data_out", u_if.data_out, 8'h00);
    check("midrst_load", u_if.load, 1'b0);
    reset = 1'b0;
    step(CPB / 2 + 4 * CPB + 10);
    check("midrst_no_load", load_cnt - n_load0, 0);
    check("midrst_no_ferr", ferr_cnt - n_ferr0, 0);
    check("midrst_data_kept", u_if.data_out, 8'h00);
    fall_cyc = cyc;
    send_frame(8'h5A, 1'b1);
    step(5);
    check("post_rst_load_count", load_cnt - n_load0, 1);
    check("post_rst_latency", (load_cyc_q.size() > n_load0) ? load_cyc_q[n_load0] - fall_cyc : -1, LOAD_LAT);
    check("post_rst_data_out", u_if.data_out, 8'h5A);

    // rx toggles while reset is held high
    n_load0 = load_cnt;
    n_ferr0 = ferr_cnt;
    reset   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      u_if.rx = (i % 3 == 0) ? 1'b0 : 1'b1;
      step(1);
      check("rst_hold_outputs", {u_if.busy, u_if.load, u_if.frame_err, u_if.data_out}, 32'h0);
    end
    u_if.rx = 1'b1;
    step(2);
    reset = 1'b0;
    step(5);
    check("rst_hold_no_load", load_cnt - n_load0, 0);
    check("rst_hold_no_ferr", ferr_cnt - n_ferr0, 0);
    check("rst_release_idle", {u_if.busy, u_if.data_out}, 32'h0);
    check("never_load_and_ferr", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_receptor_serial_byte
